// File: rtl/m_decode_sequencer_if.sv
// Load/decode bundle for m_decode_sequencer.
// master: the register-file side that offers words and consumes strobes.
// slave : the sequencer itself.
interface m_decode_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
);
  // Load handshake
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  // Stall request, only meaningful while scanning
  logic             hold;

  // Decode strobes and progress reporting
  logic [WIDTH-1:0] decode;
  logic             decode_valid;
  logic [IDX_W-1:0] decode_idx;
  logic [IDX_W:0]   strobe_cnt;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    output hold,
    input  load_ready,
    input  decode,
    input  decode_valid,
    input  decode_idx,
    input  strobe_cnt,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  hold,
    output load_ready,
    output decode,
    output decode_valid,
    output decode_idx,
    output strobe_cnt,
    output busy,
    output done
  );
endinterface

// File: rtl/m_decode_sequencer.sv
// Decode sequencer: accepts one register word and replays it as a series of
// one-hot decode strobes, decode0 (word bit 7) first through decode7 (bit 0).
// Every position takes one scan cycle whether its bit is set or not, so the
// latency from load to done is fixed (plus any hold cycles).
module m_decode_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input logic                  clk,
  input logic                  reset,
  m_decode_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
  localparam logic [IDX_W:0]   CntOne  = (IDX_W + 1)'(1);

  state_e           state_q, state_d;
  // Word is shifted left as it is scanned, so the MSB is always the bit for decode_idx.
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;

  logic             cur_bit;
  logic             scan_step;
  logic [WIDTH-1:0] decode;

  assign cur_bit   = word_q[WIDTH-1];
  // A scan position is consumed only on a cycle without a stall.
  assign scan_step = (state_q == StScan) && !bus.hold;

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: capture in idle, step one position per unstalled scan cycle.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          word_d  = bus.load_data;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (scan_step) begin
          if (cur_bit) begin
            cnt_d = cnt_q + CntOne;
          end
          word_d = {word_q[WIDTH-2:0], 1'b0};
          // Index parks at the last position through DONE and wraps on the way to IDLE.
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end
      StDone: begin
        // strobe_cnt keeps the final popcount until the next accepted load.
        idx_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobe decode: one line at most, only for a set bit on an unstalled scan cycle.
  always_comb begin
    decode = '0;
    if (scan_step && cur_bit) begin
      decode[idx_q] = 1'b1;
    end
  end

  assign bus.decode       = decode;
  assign bus.decode_valid = |decode;
  assign bus.decode_idx   = idx_q;
  assign bus.strobe_cnt   = cnt_q;
  assign bus.load_ready   = (state_q == StIdle);
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = (state_q == StDone);

endmodule
